// File: rtl/port_link_if.sv
// port_link_if: request/response handshake and port-direction bundle of port_link_ctrl
//   req_valid/req_write/req_data : request from the master
//   req_ready                    : request accepted when valid & ready
//   done                         : one-cycle transfer-complete pulse
//   rsp_data                     : last byte read from the bus
//   port_dir                     : port in_out_en (1 = port drives bus)
//   xfer_count                   : completed transfers, modulo 256
interface port_link_if;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_data;
    logic       req_ready;
    logic       done;
    logic [7:0] rsp_data;
    logic       port_dir;
    logic [7:0] xfer_count;
    modport master (
        output req_valid, req_write, req_data,
        input  req_ready, done, rsp_data, port_dir, xfer_count
    );
    modport slave (
        input  req_valid, req_write, req_data,
        output req_ready, done, rsp_data, port_dir, xfer_count
    );
endinterface

// File: rtl/port_link_ctrl.sv
// port_link_ctrl: fixed-latency byte transfer controller for a bidirectional port bus
//   clk   : clock, all state on rising edge
//   clear : synchronous active-high reset
//   lnk   : request/response/port-direction bundle (slave side)
//   bus   : shared 8-bit bus to the port, driven only while writing
module port_link_ctrl (
    input  logic              clk,
    input  logic              clear,
    port_link_if.slave        lnk,
    inout  wire         [7:0] bus
);
    typedef enum logic [2:0] {IDLE, WR_DRV, WR_REL, RD_TURN, RD_SMP, RD_REL} state_t;
    state_t     state_q;
    logic       cnt_q;
    logic       ready_q;
    logic       dir_q;
    logic       oe_q;
    logic       done_q;
    logic [7:0] data_q;
    logic [7:0] rsp_q;
    logic [7:0] count_q;
    // Bus enable is a register that is only set from IDLE into WR_DRV, so
    // port_dir (only set on the read path) can never overlap a drive cycle.
    assign bus            = oe_q ? data_q : 8'hzz;
    assign lnk.req_ready  = ready_q;
    assign lnk.done       = done_q;
    assign lnk.rsp_data   = rsp_q;
    assign lnk.port_dir   = dir_q;
    assign lnk.xfer_count = count_q;
    // Outputs are updated on the same edge as the state they belong to,
    // so each output register already holds the value for the entered state.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= 1'b0;
            ready_q <= 1'b1;
            dir_q   <= 1'b0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
            rsp_q   <= 8'h00;
            count_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lnk.req_valid) begin
                        data_q  <= lnk.req_data;
                        ready_q <= 1'b0;
                        cnt_q   <= 1'b0;
                        state_q <= lnk.req_write ? WR_DRV : RD_TURN;
                        oe_q    <= lnk.req_write;
                        dir_q   <= ~lnk.req_write;
                    end
                end
                WR_DRV: begin
                    cnt_q <= 1'b1;
                    if (cnt_q) begin
                        state_q <= WR_REL;
                        oe_q    <= 1'b0;
                        done_q  <= 1'b1;
                        count_q <= count_q + 8'd1;
                    end
                end
                RD_TURN: state_q <= RD_SMP;
                RD_SMP: begin
                    state_q <= RD_REL;
                    dir_q   <= 1'b0;
                    rsp_q   <= bus;
                    done_q  <= 1'b1;
                    count_q <= count_q + 8'd1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_port_link_ctrl.sv
// tb_port_link_ctrl: directed scoreboard bench for port_link_ctrl
module tb_port_link_ctrl;
    typedef struct packed {
        logic [7:0] rsp;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [7:0] port_q = 8'h00;
    wire  [7:0] bus;
    exp_t       sb[$];
    logic [7:0] exp_rsp = 8'h00;
    logic [7:0] exp_cnt = 8'h00;
    int         passed = 0;
    int         total = 0;

    port_link_if ifc ();
    port_link_ctrl dut (.clk(clk), .clear(clear), .lnk(ifc.slave), .bus(bus));

    assign bus = ifc.port_dir ? port_q : 8'hzz;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ifc.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_rsp_data", ifc.rsp_data, e.rsp);
                check("sb_xfer_count", ifc.xfer_count, e.cnt);
            end
        end
    end

    task automatic do_xfer(input logic wr, input logic [7:0] d, input logic hold);
        ifc.req_valid = 1'b1;
        ifc.req_write = wr;
        ifc.req_data  = d;
        check("accept_ready", {7'd0, ifc.req_ready}, 8'd1);
        if (!wr) exp_rsp = port_q;
        exp_cnt = exp_cnt + 8'd1;
        sb.push_back({exp_rsp, exp_cnt});
        tick;
        if (!hold) ifc.req_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            check("busy_ready", {7'd0, ifc.req_ready}, 8'd0);
            check("busy_dir", {7'd0, ifc.port_dir}, wr ? 8'd0 : 8'd1);
            check("busy_done", {7'd0, ifc.done}, 8'd0);
            if (wr) check("bus_drive", bus, d);
            if (!wr && c == 2) check("bus_port", bus, port_q);
            tick;
        end
        check("done_latency", {7'd0, ifc.done}, 8'd1);
        check("rel_dir", {7'd0, ifc.port_dir}, 8'd0);
        check("rel_ready", {7'd0, ifc.req_ready}, 8'd0);
        tick;
        check("done_pulse", {7'd0, ifc.done}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        ifc.req_valid = 1'b0;
        ifc.req_write = 1'b0;
        ifc.req_data  = 8'h00;
        tick;
        // request presented together with clear must not be accepted
        ifc.req_valid = 1'b1;
        ifc.req_write = 1'b1;
        ifc.req_data  = 8'hA5;
        tick;
        check("rst_ready", {7'd0, ifc.req_ready}, 8'd1);
        check("rst_dir", {7'd0, ifc.port_dir}, 8'd0);
        check("rst_done", {7'd0, ifc.done}, 8'd0);
        check("rst_rsp", ifc.rsp_data, 8'h00);
        check("rst_count", ifc.xfer_count, 8'h00);
        clear = 1'b0;
        do_xfer(1'b1, 8'hA5, 1'b0);
        check("wr_count", ifc.xfer_count, 8'h01);
        check("wr_rsp_kept", ifc.rsp_data, 8'h00);
        port_q = 8'h3C;
        do_xfer(1'b0, 8'h00, 1'b0);
        check("rd_rsp", ifc.rsp_data, 8'h3C);
        check("rd_count", ifc.xfer_count, 8'h02);
        // back-to-back with req_valid held across both transfers
        port_q = 8'hC7;
        do_xfer(1'b1, 8'h11, 1'b1);
        do_xfer(1'b0, 8'h11, 1'b0);
        check("b2b_rsp", ifc.rsp_data, 8'hC7);
        check("b2b_count", ifc.xfer_count, 8'h04);
        // clear during the second WR_DRV cycle aborts the write
        ifc.req_valid = 1'b1;
        ifc.req_write = 1'b1;
        ifc.req_data  = 8'h77;
        tick;
        ifc.req_valid = 1'b0;
        tick;
        check("abort_bus", bus, 8'h77);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        exp_cnt = 8'h00;
        exp_rsp = 8'h00;
        check("abort_ready", {7'd0, ifc.req_ready}, 8'd1);
        check("abort_dir", {7'd0, ifc.port_dir}, 8'd0);
        check("abort_done", {7'd0, ifc.done}, 8'd0);
        check("abort_count", ifc.xfer_count, 8'h00);
        check("abort_rsp", ifc.rsp_data, 8'h00);
        tick;
        check("abort_no_done", {7'd0, ifc.done}, 8'd0);
        // 256 transfers from reset wrap the counter to zero
        for (int i = 0; i < 256; i++) begin
            port_q = 8'(i) ^ 8'h5A;
            do_xfer(i[0], 8'(i), 1'b0);
        end
        check("wrap_count", ifc.xfer_count, 8'h00);
        check("wrap_rsp", ifc.rsp_data, 8'hFE ^ 8'h5A);
        tick;
        check("sb_empty", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
